itof_pipe: RTL and testbench
============================

// Module: itof_pipe
// PURPOSE
//  Pipelined signed 32-bit integer -> IEEE-754 single converter; inverse of the FPU's float->int unit.
//  Sits in the FPU next to ftoi; fed by the core's FPU issue logic, result goes to FPU writeback.
//  Valid/ready handshake on both sides; fully pipelined, one conversion per cycle when unstalled.
// PARAMETERS
//  REG_IN  1  1: register input (latency 3 cycles); 0: stage 1 combinational from inputs (latency 2)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rstn       in   1   asynchronous active-low reset
//  valid_in   in   1   s is valid this cycle
//  ready_in   out  1   block accepts s this cycle
//  s          in   32  two's-complement signed integer
//  valid_out  out  1   d is valid
//  ready_out  in   1   consumer takes d this cycle
//  d          out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
//  inexact    out  1   only with ITOF_INEXACT_EN: conversion was rounded (aligned with d)
// BEHAVIOUR
//  Reset: valid_out=0, d=32'h0, inexact=0, all internal stage valids=0; in-flight ops dropped.
//  Handshake: transfer on valid_in&&ready_in (input), valid_out&&ready_out (output).
//   Each stage advances when its successor is empty or advancing; ready_in = !v1 || stage-1 advances.
//   With valid_out&&!ready_out: d, inexact, valid_out held stable; no op lost or duplicated.
//   ready_in may depend combinationally on ready_out; back-to-back accepts sustain 1 op/cycle.
//  Stage 1: sign=s[31]; mag=sign ? -s : s (33-bit safe; -2^31 -> mag 2^31).
//  Stage 2: lz=leading zeros of mag (0..32); norm=mag<<lz (bit31 = implicit 1); zero=(mag==0).
//  Stage 3: exp=8'd158-lz; frac=norm[30:8]; g=norm[7], st=|norm[6:0].
//   Round-to-nearest-even: up = g && (st || frac[0]).
//   frac+up overflow (frac all-ones): frac=0, exp+1. Max exp is 158 (2^31); no inf/NaN possible.
//   zero input -> d=32'h0000_0000 (+0), never -0.
//  Inputs with |s| < 2^24 are exact; only |s| >= 2^24 can round.
//  Latency: REG_IN=1 -> d valid 3 cycles after accept; REG_IN=0 -> 2 cycles (no stall).
//  Reset asserted mid-stream: outputs return to reset values asynchronously; restarts clean.
// CONFIGURATION
//  ITOF_INEXACT_EN defined: port inexact present, = (g||st) of the op carried with d; reset 0.
//  ITOF_INEXACT_EN undefined: port and its pipeline bits absent; d/timing identical.
// STRUCTURE
//  Shared FPU package: FP32 field widths/positions, EXP_BIAS=127, lz-to-exp constant 158, fp32_t typedef.
//  Sub-module: lzc32 (combinational 32-bit leading-zero counter, output 6 bits, 32 for zero input).
//  Top holds stage registers, handshake control, rounding/packing.
// TESTING
//  s=0,1,-1 -> d=32'h00000000, 32'h3F800000, 32'hBF800000; inexact=0.
//  s=32'h80000000 -> 32'hCF000000; s=32'h7FFFFFFF -> 32'h4F000000 (round carry into exp), inexact=1.
//  s=16777217 -> 32'h4B800000 (tie to even); s=16777219 -> 32'h4B800002 (tie up); both inexact=1.
//  Stream 16 random s back-to-back, ready_out=1 -> one result/cycle, latency 3, d==ref model.
//  Random ready_out toggling (~50%) over 1000 ops -> d stable while stalled, order kept, no loss/dup.
//  Assert rstn low with 3 ops in flight -> valid_out=0 immediately; next op after release is correct.

Source files
------------

// File: rtl/itof_pipe_pkg.sv
// Shared FPU definitions: FP32 field layout, exponent bias and the
// leading-zero to exponent constant used by the int->float converter.
package itof_pipe_pkg;

  localparam int FP32_W   = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  // Exponent of a 32-bit magnitude whose MSB sits at bit 31 is bias+31.
  localparam logic [EXP_W-1:0] LZ_EXP_BASE = EXP_W'(EXP_BIAS + FP32_W - 1);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/itof_pipe_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  lz
);

  always_comb begin
    lz = 6'd32;
    // Higher bits are visited last, so the most significant set bit wins.
    for (int i = 0; i < 32; i++) begin
      if (a[i]) lz = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Pipelined signed 32-bit integer to IEEE-754 single converter with valid/ready
// on both sides. Define ITOF_INEXACT_EN to add the inexact flag output.
module itof_pipe
  import itof_pipe_pkg::*;
#(
  parameter int REG_IN = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [31:0] s,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] d
`ifdef ITOF_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  logic        en2;
  logic        en3;

  logic        in_sign;
  logic [31:0] in_mag;

  logic        s1_valid;
  logic        s1_sign;
  logic [31:0] s1_mag;
  logic [5:0]  s1_lz;
  logic [31:0] s1_norm;

  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic [5:0]  s2_lz;
  logic [30:0] s2_norm;

  logic [FRAC_W-1:0] frac_pre;
  logic [FRAC_W:0]   frac_sum;
  logic              g;
  logic              st;
  logic              up;
  fp32_t             res;

  // 32-bit negate is enough: -2^31 wraps to 0x8000_0000, the correct unsigned magnitude.
  assign in_sign = s[31];
  assign in_mag  = in_sign ? (32'd0 - s) : s;

  assign en3 = !valid_out || ready_out;
  assign en2 = !s2_valid || en3;

  generate
    if (REG_IN != 0) begin : g_reg_in
      assign ready_in = !s1_valid || en2;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_valid <= 1'b0;
          s1_sign  <= 1'b0;
          s1_mag   <= '0;
        end else if (ready_in) begin
          s1_valid <= valid_in;
          if (valid_in) begin
            s1_sign <= in_sign;
            s1_mag  <= in_mag;
          end
        end
      end
    end else begin : g_comb_in
      assign ready_in = en2;
      assign s1_valid = valid_in;
      assign s1_sign  = in_sign;
      assign s1_mag   = in_mag;
    end
  endgenerate

  lzc32 u_lzc (
    .a  (s1_mag),
    .lz (s1_lz)
  );

  assign s1_norm = s1_mag << s1_lz;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_lz    <= '0;
      s2_norm  <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= (s1_mag == 32'd0);
        s2_lz   <= s1_lz;
        s2_norm <= s1_norm[30:0];
      end
    end
  end

  // Round to nearest even; a carry out of the fraction bumps the exponent.
  always_comb begin
    frac_pre = s2_norm[30:8];
    g        = s2_norm[7];
    st       = |s2_norm[6:0];
    up       = g && (st || frac_pre[0]);
    frac_sum = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, up};
    res      = '0;
    if (!s2_zero) begin
      res.sign = s2_sign;
      res.exp  = LZ_EXP_BASE - {2'b00, s2_lz} + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
      res.frac = frac_sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      d         <= '0;
    end else if (en3) begin
      valid_out <= s2_valid;
      if (s2_valid) d <= res;
    end
  end

`ifdef ITOF_INEXACT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inexact <= 1'b0;
    end else if (en3 && s2_valid) begin
      inexact <= g || st;
    end
  end
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed corner values, random streams
// and random output back-pressure, checked against an arithmetic reference.
module tb_itof_pipe;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] s;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] d;
`ifdef ITOF_INEXACT_EN
  logic        inexact;
`endif

  itof_pipe #(.REG_IN(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .s         (s),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .d         (d)
`ifdef ITOF_INEXACT_EN
    ,
    .inexact   (inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        inx;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          hold_chk = 0;
  logic [31:0] hold_d;
  logic        hold_inx;
  bit          last_acc = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: keep the top 24 significant bits of |x|, round the remainder
  // to nearest even, renormalise on carry. Returns {inexact, float bits}.
  function automatic logic [32:0] ref_itof(input logic [31:0] x);
    longint m, q, rem, half;
    int     e;
    logic   sg;
    logic [7:0] ex;
    sg = x[31];
    m  = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) return 33'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (m >= (64'sd1 <<< i)) e = i;
    rem = 0;
    if (e <= 23) begin
      q = m <<< (23 - e);
    end else begin
      q    = m >>> (e - 23);
      rem  = m - (q <<< (e - 23));
      half = 64'sd1 <<< (e - 24);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        e = e + 1;
      end
    end
    ex = 8'(e + 127);
    return {rem != 0, sg, ex, q[22:0]};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] x;
    x = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
    return x;
  endfunction

  // One clock: drive at negedge, observe 1 ns later, account transfers.
  task automatic step(input logic v, input logic [31:0] sv, input logic r,
                      input logic [31:0] ed, input logic ei, input bit lat_chk);
    exp_t e;
    @(negedge clk);
    valid_in  = v;
    s         = sv;
    ready_out = r;
    #1;
    if (hold_chk) begin
      chk1("stall_valid_held", valid_out, 1'b1);
      chk32("stall_d_held", d, hold_d);
`ifdef ITOF_INEXACT_EN
      chk1("stall_inexact_held", inexact, hold_inx);
`endif
    end
    hold_chk = valid_out && !ready_out;
    hold_d   = d;
`ifdef ITOF_INEXACT_EN
    hold_inx = inexact;
`endif
    if (valid_out && ready_out) begin
      chk1("output_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("d", d, e.d);
`ifdef ITOF_INEXACT_EN
        chk1("inexact", inexact, e.inx);
`endif
        if (lat_chk) chk32("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
    last_acc = v && ready_in;
    if (last_acc) begin
      e.d   = ed;
      e.inx = ei;
      e.cyc = cyc;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain(input bit lat_chk);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, lat_chk);
      n++;
    end
    chk1("drain_complete", sb.size() == 0, 1'b1);
  endtask

  task automatic send(input logic [31:0] sv, input logic [31:0] ed, input logic ei);
    int n;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < 20) begin
      step(1'b1, sv, 1'b1, ed, ei, 1'b0);
      n++;
    end
    chk1("accept_in_time", last_acc, 1'b1);
    step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] x;
    logic        v;
    int          sent;
    int          n;
    bit          have;

    rstn      = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    s         = 32'd0;
    #12;
    chk1("reset_valid_out", valid_out, 1'b0);
    chk32("reset_d", d, 32'h0);
    chk1("reset_ready_in", ready_in, 1'b1);
`ifdef ITOF_INEXACT_EN
    chk1("reset_inexact", inexact, 1'b0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    send(32'd0,        32'h0000_0000, 1'b0);
    send(32'd1,        32'h3F80_0000, 1'b0);
    send(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
    send(32'h8000_0000, 32'hCF00_0000, 1'b0);
    send(32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
    send(32'd16777217, 32'h4B80_0000, 1'b1);
    send(32'd16777219, 32'h4B80_0002, 1'b1);
    send(32'd16777215, 32'h4B7F_FFFF, 1'b0);
    drain(1'b0);

    for (int i = 0; i < 16; i++) begin
      x = rand_val();
      r = ref_itof(x);
      step(1'b1, x, 1'b1, r[31:0], r[32], 1'b1);
      chk1("stream_accept", last_acc, 1'b1);
    end
    drain(1'b1);

    sent = 0;
    n    = 0;
    have = 0;
    x    = 32'd0;
    while (sent < 1000 && n < 20000) begin
      if (!have) begin
        x    = rand_val();
        have = 1;
      end
      v = ($urandom_range(0, 3) != 0);
      r = ref_itof(x);
      step(v, x, ($urandom_range(0, 1) == 1), r[31:0], r[32], 1'b0);
      if (last_acc) begin
        sent++;
        have = 0;
      end
      n++;
    end
    chk1("random_all_sent", sent == 1000, 1'b1);
    drain(1'b0);

    for (int i = 0; i < 3; i++) begin
      x = rand_val();
      r = ref_itof(x);
      step(1'b1, x, 1'b1, r[31:0], r[32], 1'b0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rstn     = 1'b0;
    #1;
    chk1("midreset_valid_out", valid_out, 1'b0);
    chk32("midreset_d", d, 32'h0);
`ifdef ITOF_INEXACT_EN
    chk1("midreset_inexact", inexact, 1'b0);
`endif
    sb.delete();
    hold_chk = 0;
    @(negedge clk);
    rstn = 1'b1;
    send(32'hFFFF_FFF6, 32'hC120_0000, 1'b0);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
